// File: rtl/tea_pkg.sv
// Shared TEA definitions used by the packer and the downstream unpacker.
//   DELTA       : TEA key-schedule constant
//   BLOCK_W     : cipher block width in bits
//   BYTE_W      : stream byte width in bits
//   state_e     : packer FSM states
//   slot_lsb()  : bit offset of byte slot k inside a block for a given byte order
package tea_pkg;

    localparam logic [31:0] DELTA   = 32'h9e37_79b9;
    localparam int unsigned BLOCK_W = 64;
    localparam int unsigned BYTE_W  = 8;

    typedef enum logic [1:0] {
        COLLECT,
        PAD,
        HOLD
    } state_e;

    // Big-endian slot k occupies bits [63-8k:56-8k], i.e. LSB at 8*(7-k);
    // little-endian slot k occupies bits [8k+7:8k].
    function automatic logic [5:0] slot_lsb(input logic [2:0] slot, input logic big_endian);
        if (big_endian) begin
            return {~slot, 3'b000};
        end
        return {slot, 3'b000};
    endfunction

endpackage

// File: rtl/tea_blk_reg.sv
// Output holding register for assembled TEA blocks.
// Ports:
//   clk, rst   : clock, asynchronous active-high reset
//   ena        : global enable, 0 freezes the register
//   load_i     : load data_i/last_i/pad_i as a new valid block
//   data_i, last_i, pad_i : block to load
//   ready_i    : downstream accepts the block when valid_o && ready_i
//   data_o, valid_o, last_o, pad_o : registered block presented downstream
module tea_blk_reg
    import tea_pkg::*;
(
    input  logic               clk,
    input  logic               rst,
    input  logic               ena,
    input  logic               load_i,
    input  logic [BLOCK_W-1:0] data_i,
    input  logic               last_i,
    input  logic [2:0]         pad_i,
    input  logic               ready_i,
    output logic [BLOCK_W-1:0] data_o,
    output logic               valid_o,
    output logic               last_o,
    output logic [2:0]         pad_o
);

    logic [BLOCK_W-1:0] data_q, data_d;
    logic               valid_q, valid_d;
    logic               last_q, last_d;
    logic [2:0]         pad_q, pad_d;

    // A load wins over a consume on the same edge, so back-to-back blocks keep valid high.
    always_comb begin
        data_d  = data_q;
        valid_d = valid_q;
        last_d  = last_q;
        pad_d   = pad_q;
        if (ena) begin
            if (load_i) begin
                data_d  = data_i;
                valid_d = 1'b1;
                last_d  = last_i;
                pad_d   = pad_i;
            end else if (valid_q && ready_i) begin
                valid_d = 1'b0;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            data_q  <= '0;
            valid_q <= 1'b0;
            last_q  <= 1'b0;
            pad_q   <= '0;
        end else begin
            data_q  <= data_d;
            valid_q <= valid_d;
            last_q  <= last_d;
            pad_q   <= pad_d;
        end
    end

    assign data_o  = data_q;
    assign valid_o = valid_q;
    assign last_o  = last_q;
    assign pad_o   = pad_q;

endmodule

// File: rtl/tea_block_packer.sv
// Packs a valid/ready byte stream into 64-bit blocks for the TEA encryptor,
// padding a short final block with PAD_BYTE.
// Ports:
//   clk, rst   : clock, asynchronous active-high reset
//   ena        : global enable, 0 freezes all state
//   in_data, in_valid, in_last, in_ready : byte input handshake
//   blk_data, blk_valid, blk_last, blk_pad, blk_ready : block output handshake
module tea_block_packer
    import tea_pkg::*;
#(
    parameter logic [7:0] PAD_BYTE   = 8'h00,
    parameter bit         BIG_ENDIAN = 1'b1
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               ena,
    input  logic [BYTE_W-1:0]  in_data,
    input  logic               in_valid,
    input  logic               in_last,
    output logic               in_ready,
    output logic [BLOCK_W-1:0] blk_data,
    output logic               blk_valid,
    output logic               blk_last,
    output logic [2:0]         blk_pad,
    input  logic               blk_ready
);

    state_e             state_q, state_d;
    logic [2:0]         idx_q, idx_d;
    logic [BLOCK_W-1:0] asm_q, asm_d;
    logic [2:0]         pad_q, pad_d;
    logic               last_q, last_d;

    logic               out_free;
    logic [BYTE_W-1:0]  wr_byte;
    logic [5:0]         wr_off;
    logic [BLOCK_W-1:0] merged;
    logic               complete;
    logic               cmp_last;
    logic [2:0]         cmp_pad;
    logic               load;
    logic [BLOCK_W-1:0] ld_data;
    logic               ld_last;
    logic [2:0]         ld_pad;

    assign out_free = !blk_valid || blk_ready;

    // Assembly register with the current byte (or pad byte) written into slot idx.
    assign wr_byte = (state_q == PAD) ? PAD_BYTE : in_data;
    assign wr_off  = slot_lsb(idx_q, BIG_ENDIAN);
    assign merged  = (asm_q & ~({{(BLOCK_W-BYTE_W){1'b0}}, {BYTE_W{1'b1}}} << wr_off))
                   | ({{(BLOCK_W-BYTE_W){1'b0}}, wr_byte} << wr_off);

    always_comb begin
        state_d  = state_q;
        idx_d    = idx_q;
        asm_d    = asm_q;
        pad_d    = pad_q;
        last_d   = last_q;
        in_ready = 1'b0;
        complete = 1'b0;
        cmp_last = last_q;
        cmp_pad  = pad_q;
        load     = 1'b0;
        ld_data  = asm_q;
        ld_last  = last_q;
        ld_pad   = pad_q;

        unique case (state_q)
            COLLECT: begin
                in_ready = ena;
                if (ena && in_valid) begin
                    if (idx_q == 3'd7) begin
                        complete = 1'b1;
                        cmp_last = in_last;
                        cmp_pad  = 3'd0;
                    end else begin
                        asm_d = merged;
                        idx_d = idx_q + 3'd1;
                        if (in_last) begin
                            pad_d   = 3'd7 - idx_q;
                            last_d  = 1'b1;
                            state_d = PAD;
                        end
                    end
                end
            end
            PAD: begin
                if (ena) begin
                    if (idx_q == 3'd7) begin
                        complete = 1'b1;
                        cmp_last = 1'b1;
                        cmp_pad  = pad_q;
                    end else begin
                        asm_d = merged;
                        idx_d = idx_q + 3'd1;
                    end
                end
            end
            HOLD: begin
                if (ena && out_free) begin
                    load    = 1'b1;
                    ld_data = asm_q;
                    ld_last = last_q;
                    ld_pad  = pad_q;
                    asm_d   = '0;
                    idx_d   = '0;
                    state_d = COLLECT;
                end
            end
            default: state_d = COLLECT;
        endcase

        // The completing byte bypasses the assembly register when the output is free;
        // otherwise the full block parks in asm_q until HOLD can hand it over.
        if (complete) begin
            if (out_free) begin
                load    = 1'b1;
                ld_data = merged;
                ld_last = cmp_last;
                ld_pad  = cmp_pad;
                asm_d   = '0;
                idx_d   = '0;
                state_d = COLLECT;
            end else begin
                asm_d   = merged;
                last_d  = cmp_last;
                pad_d   = cmp_pad;
                state_d = HOLD;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= COLLECT;
            idx_q   <= '0;
            asm_q   <= '0;
            pad_q   <= '0;
            last_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            asm_q   <= asm_d;
            pad_q   <= pad_d;
            last_q  <= last_d;
        end
    end

    tea_blk_reg u_blk_reg (
        .clk     (clk),
        .rst     (rst),
        .ena     (ena),
        .load_i  (load),
        .data_i  (ld_data),
        .last_i  (ld_last),
        .pad_i   (ld_pad),
        .ready_i (blk_ready),
        .data_o  (blk_data),
        .valid_o (blk_valid),
        .last_o  (blk_last),
        .pad_o   (blk_pad)
    );

endmodule

// File: tb/tb_tea_block_packer.sv
// Bench for tea_block_packer: a big-endian instance (PAD_BYTE=00) and a
// little-endian instance (PAD_BYTE=A5) share one input stream and are both
// compared every cycle against a message-level reference model.
module tb_tea_block_packer;

    logic        clk = 1'b0;
    logic        rst;
    logic        ena;
    logic [7:0]  in_data;
    logic        in_valid;
    logic        in_last;
    logic        blk_ready;

    logic        rdy_be, rdy_le;
    logic [63:0] d_be, d_le;
    logic        v_be, v_le, l_be, l_le;
    logic [2:0]  p_be, p_le;

    always #5 clk = ~clk;

    tea_block_packer #(.PAD_BYTE(8'h00), .BIG_ENDIAN(1'b1)) dut_be (
        .clk(clk), .rst(rst), .ena(ena),
        .in_data(in_data), .in_valid(in_valid), .in_last(in_last), .in_ready(rdy_be),
        .blk_data(d_be), .blk_valid(v_be), .blk_last(l_be), .blk_pad(p_be),
        .blk_ready(blk_ready)
    );

    tea_block_packer #(.PAD_BYTE(8'hA5), .BIG_ENDIAN(1'b0)) dut_le (
        .clk(clk), .rst(rst), .ena(ena),
        .in_data(in_data), .in_valid(in_valid), .in_last(in_last), .in_ready(rdy_le),
        .blk_data(d_le), .blk_valid(v_le), .blk_last(l_le), .blk_pad(p_le),
        .blk_ready(blk_ready)
    );

    int unsigned n_checks = 0;
    int unsigned n_fail   = 0;

    // Reference model: bytes of the block in progress, pad cycles still owed,
    // a parked block when the output is busy, and the presented output block.
    logic [7:0]  m_bytes[$];
    int          m_pad_left;
    int          m_npad;
    bit          m_hold;
    logic [63:0] m_hold_be, m_hold_le;
    bit          m_hold_last;
    int          m_hold_pad;
    bit          m_v, m_l;
    logic [2:0]  m_p;
    logic [63:0] m_d_be, m_d_le;

    task automatic model_reset();
        m_bytes.delete();
        m_pad_left = 0; m_npad = 0;
        m_hold = 0; m_hold_be = '0; m_hold_le = '0; m_hold_last = 0; m_hold_pad = 0;
        m_v = 0; m_l = 0; m_p = '0; m_d_be = '0; m_d_le = '0;
    endtask

    function automatic logic [63:0] build(input bit be, input logic [7:0] pad);
        logic [63:0] r;
        logic [7:0]  b;
        r = '0;
        for (int k = 0; k < 8; k++) begin
            b = (k < m_bytes.size()) ? m_bytes[k] : pad;
            if (be) r[63-8*k -: 8] = b;
            else    r[8*k +: 8]    = b;
        end
        return r;
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Advance the model across one clock edge using the inputs currently driven.
    task automatic model_step();
        bit          free;
        bit          loaded;
        bit          done;
        bit          dlast;
        int          dpad;
        logic [63:0] be_blk, le_blk;
        free = !m_v || blk_ready;
        loaded = 0; done = 0; dlast = 0; dpad = 0;
        if (!ena) return;
        if (m_hold) begin
            if (free) begin
                m_v = 1; m_d_be = m_hold_be; m_d_le = m_hold_le;
                m_l = m_hold_last; m_p = 3'(m_hold_pad);
                m_hold = 0; loaded = 1;
            end
        end else if (m_pad_left > 0) begin
            m_pad_left--;
            if (m_pad_left == 0) begin done = 1; dlast = 1; dpad = m_npad; end
        end else if (in_valid) begin
            m_bytes.push_back(in_data);
            if (m_bytes.size() == 8) begin
                done = 1; dlast = in_last; dpad = 0;
            end else if (in_last) begin
                m_pad_left = 8 - m_bytes.size();
                m_npad = m_pad_left;
            end
        end
        if (done) begin
            be_blk = build(1'b1, 8'h00);
            le_blk = build(1'b0, 8'hA5);
            m_bytes.delete();
            if (free) begin
                m_v = 1; m_d_be = be_blk; m_d_le = le_blk; m_l = dlast; m_p = 3'(dpad);
                loaded = 1;
            end else begin
                m_hold = 1; m_hold_be = be_blk; m_hold_le = le_blk;
                m_hold_last = dlast; m_hold_pad = dpad;
            end
        end
        if (!loaded && m_v && blk_ready) m_v = 0;
    endtask

    task automatic chk_outputs();
        chk("blk_valid_be", 64'(v_be), 64'(m_v));
        chk("blk_valid_le", 64'(v_le), 64'(m_v));
        chk("blk_data_be", d_be, m_d_be);
        chk("blk_data_le", d_le, m_d_le);
        chk("blk_last_be", 64'(l_be), 64'(m_l));
        chk("blk_last_le", 64'(l_le), 64'(m_l));
        chk("blk_pad_be", 64'(p_be), 64'(m_p));
        chk("blk_pad_le", 64'(p_le), 64'(m_p));
    endtask

    task automatic cyc(input bit e, input bit v, input logic [7:0] d, input bit l, input bit r);
        bit exp_rdy;
        @(negedge clk);
        ena = e; in_valid = v; in_data = d; in_last = l; blk_ready = r;
        #1;
        exp_rdy = e && !m_hold && (m_pad_left == 0);
        chk("in_ready_be", 64'(rdy_be), 64'(exp_rdy));
        chk("in_ready_le", 64'(rdy_le), 64'(exp_rdy));
        model_step();
        @(posedge clk);
        #1;
        chk_outputs();
    endtask

    initial begin
        rst = 1'b1; ena = 1'b0; in_valid = 1'b0; in_data = '0; in_last = 1'b0; blk_ready = 1'b0;
        model_reset();
        #2;
        chk_outputs();
        chk("in_ready_reset", 64'(rdy_be), 64'd0);
        @(negedge clk);
        rst = 1'b0;

        // Full block 01..08, last on slot 7, consumer always ready.
        for (int i = 1; i <= 8; i++) cyc(1, 1, 8'(i), i == 8, 1);
        chk("full_block_be", d_be, 64'h0102030405060708);
        chk("full_block_le", d_le, 64'h0807060504030201);
        cyc(1, 0, 8'h00, 0, 1);
        cyc(1, 0, 8'h00, 0, 1);

        // Short block AA BB CC, then five pad cycles with the source still offering.
        cyc(1, 1, 8'hAA, 0, 1);
        cyc(1, 1, 8'hBB, 0, 1);
        cyc(1, 1, 8'hCC, 1, 1);
        for (int i = 0; i < 5; i++) cyc(1, 1, 8'hDD, 0, 1);
        chk("short_block_be", d_be, 64'hAABBCC0000000000);
        chk("short_block_le", d_le, 64'hA5A5A5A5A5CCBBAA);
        chk("short_pad", 64'(p_be), 64'd5);
        cyc(1, 0, 8'h00, 0, 1);
        cyc(1, 0, 8'h00, 0, 1);

        // Backpressure: 16 bytes with the consumer stalled, then release.
        for (int i = 0; i < 16; i++) cyc(1, 1, 8'(i), 0, 0);
        chk("bp_first_be", d_be, 64'h0001020304050607);
        for (int i = 0; i < 3; i++) cyc(1, 1, 8'h55, 0, 0);
        cyc(1, 1, 8'h55, 0, 1);
        chk("bp_second_be", d_be, 64'h08090A0B0C0D0E0F);
        cyc(1, 0, 8'h00, 0, 1);
        cyc(1, 0, 8'h00, 0, 1);

        // Enable freeze after three bytes; offered byte must not be taken.
        for (int i = 1; i <= 3; i++) cyc(1, 1, 8'(8'h10 + i), 0, 0);
        for (int i = 0; i < 4; i++) cyc(0, 1, 8'h14, 0, 1);
        for (int i = 4; i <= 8; i++) cyc(1, 1, 8'(8'h10 + i), i == 8, 1);
        chk("freeze_block_be", d_be, 64'h1112131415161718);
        cyc(1, 0, 8'h00, 0, 1);

        // Asynchronous reset in the middle of PAD.
        cyc(1, 1, 8'h77, 0, 1);
        cyc(1, 1, 8'h88, 1, 1);
        cyc(1, 0, 8'h00, 0, 1);
        cyc(1, 0, 8'h00, 0, 1);
        @(negedge clk);
        #2 rst = 1'b1;
        #1;
        model_reset();
        chk_outputs();
        #1 rst = 1'b0;
        for (int i = 0; i < 8; i++) cyc(1, 1, 8'(8'hE0 + i), i == 7, 1);
        chk("post_reset_be", d_be, 64'hE0E1E2E3E4E5E6E7);
        chk("post_reset_le", d_le, 64'hE7E6E5E4E3E2E1E0);

        // Randomized traffic.
        for (int i = 0; i < 600; i++) begin
            cyc($urandom_range(0, 9) != 0, $urandom_range(0, 9) < 7, 8'($urandom),
                $urandom_range(0, 9) == 0, $urandom_range(0, 9) < 6);
        end

        $display("%0d/%0d checks passed", n_checks - n_fail, n_checks);
        $finish;
    end

endmodule

// File: doc/tea_block_packer.md
Name: tea_block_packer

Overview:
- Upstream stage of the TEA encrypt/decrypt datapath: converts a byte stream into 64-bit blocks for the combinational TEA encryptor's inBlock64.
- Valid/ready byte input; assembly register plus one output holding register; pads short final blocks.
- Output block stays stable while the TEA logic and its downstream capture it.

Parameters:
- PAD_BYTE, 8'h00, value written into unfilled byte slots of a short final block
- BIG_ENDIAN, 1, 1: first byte lands in bits [63:56]; 0: first byte lands in bits [7:0]

Ports:
- clk  in  1  single clock, rising edge
- rst  in  1  asynchronous, active-high reset
- ena  in  1  global enable; 0 freezes all state
- in_data  in  8  input byte
- in_valid  in  1  in_data valid
- in_last  in  1  qualifies the accepted byte as the final byte of a message
- in_ready  out  1  byte accepted when in_valid && in_ready at the clock edge
- blk_data  out  64  assembled block, to encryptor inBlock64
- blk_valid  out  1  blk_data valid
- blk_last  out  1  block is the final block of a message
- blk_pad  out  3  number of pad bytes in the block (0..7)
- blk_ready  in  1  downstream accepts the block when blk_valid && blk_ready

Behaviour:
- Reset (async, immediate): state=COLLECT, idx=0, asm=0, blk_data=0, blk_valid=0, blk_last=0, blk_pad=0. A reset mid-message or mid-PAD discards all partial data.
- ena=0: no state changes, in_ready=0, blk handshake not taken. blk_valid and blk_data hold.
- Slot k means bits [63-8k:56-8k] when BIG_ENDIAN=1, or [8k+7:8k] when BIG_ENDIAN=0. idx is 3-bit, range 0..7.
- out_free = !blk_valid || blk_ready.
- COLLECT:
  - in_ready = ena.
  - On accept: write in_data to slot idx.
  - idx<7 and !in_last: idx++.
  - idx<7 and in_last: record pad=7-idx, idx++, go to PAD.
  - idx==7: block complete (pad=0, last=in_last).
- PAD:
  - in_ready=0.
  - Each ena cycle: write PAD_BYTE to slot idx.
  - When idx==7, block complete with last=1; otherwise idx++.
- Block complete on an edge:
  - If out_free is true that cycle, the block loads into blk_data with the completing byte merged. In the same edge: blk_valid=1, blk_last/blk_pad set, idx=0, asm=0, state=COLLECT.
  - Otherwise the completed block stays in asm and state=HOLD.
- HOLD:
  - in_ready=0.
  - On the first ena cycle with out_free, load the output register, clear asm/idx, go to COLLECT.
- Output register:
  - When it is not being loaded and blk_valid && blk_ready && ena: blk_valid=0.
  - blk_data/last/pad are unchanged until the next load.
  - Simultaneous consume and load leaves blk_valid=1 with the new block.
- Latency: blk_valid rises on the same edge that accepts the 8th byte, or writes the last pad byte.
- Throughput: with blk_ready=1, one block every 8 cycles and no input bubbles.
- in_last on slot 7: full block, blk_last=1, blk_pad=0, no PAD cycles.
- in_last on slot 0: 7 PAD cycles, blk_pad=7.
- In_ready never depends combinationally on blk_ready; at most 1 stall cycle is added per HOLD exit.

Decomposition:
- Shared tea package holds:
  - DELTA, 32'h9e37_79b9
  - state enum {COLLECT, PAD, HOLD}
  - BLOCK_W=64 and BYTE_W=8
  - slot-index-to-bit-offset function, reused by the downstream unpacker
- The output holding register (data/valid/last/pad with the load/consume logic) is a natural sub-module: tea_blk_reg. The FSM and assembly logic stay in the top.

Test Plan:
- Full block, BIG_ENDIAN=1, blk_ready=1:
  - Stimulus: bytes 01..08 back-to-back, in_last on 08.
  - Response: blk_data=64'h0102030405060708, blk_last=1, blk_pad=0, blk_valid for 1 cycle after the 8th accept edge.
- Short block:
  - Stimulus: bytes AA,BB,CC, in_last on CC, PAD_BYTE=00.
  - Response: in_ready=0 for 5 cycles; blk_data=64'hAABBCC0000000000, blk_pad=5, blk_last=1.
- Backpressure:
  - Stimulus: blk_ready=0; stream 16 bytes 00..0F.
  - Response: first block 0001..07 is held; the second block waits in HOLD with in_ready=0. Raising blk_ready delivers 0x08090A0B0C0D0E0F on the next edge, then in_ready=1.
- BIG_ENDIAN=0:
  - Stimulus: bytes 01..08.
  - Response: blk_data=64'h0807060504030201.
- Enable freeze:
  - Stimulus: drop ena after byte 3, hold in_valid=1 for 4 cycles, restore ena.
  - Response: no bytes accepted while ena=0; the output register is unchanged; the final block is correct.
- Async reset during PAD:
  - Stimulus: assert rst between clock edges.
  - Response: blk_valid=0 and blk_data=0 immediately. The next 8 bytes form a clean block with no residue.
